// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side req/gnt/rvalid bundle shared by all requesters.
// Rev 1.0 - initial release.
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of a single-port DataMemory between NUM_REQ requesters.
// Option MEMARB_FIXED_PRIO_EN gives requester 0 absolute priority. Rev 1.0 - initial release.
`default_nettype none

module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    mem_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] addr_mem_o,
    output logic [DATA_W-1:0] data_to_mem_o,
    output logic              wren_o,
    input  logic [DATA_W-1:0] data_from_mem_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   pick;
    logic               found;
    logic               upd_last;
    logic               pick_we;
    logic [ADDR_W-1:0]  pick_addr;
    logic [DATA_W-1:0]  pick_wdata;
    logic [NUM_REQ-1:0] gnt_w;
    logic [NUM_REQ-1:0] rvalid_w;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int unsigned k);
        int unsigned t;
        t = 32'(base) + k;
        if (t >= 32'(NUM_REQ)) t = t - 32'(NUM_REQ);
        return IDX_W'(t);
    endfunction

    // Search starts one past the last round-robin winner and wraps.
    always_comb begin
        elig     = bus.req;
        pick     = last_q;
        found    = 1'b0;
        upd_last = 1'b0;
`ifdef MEMARB_FIXED_PRIO_EN
        elig[0]  = 1'b0;
        if (bus.req[0]) begin
            pick  = '0;
            found = 1'b1;
        end
`endif
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!found && elig[rr_idx(last_q, k)]) begin
                pick     = rr_idx(last_q, k);
                found    = 1'b1;
                upd_last = 1'b1;
            end
        end
    end

    always_comb begin
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_we    = bus.we[i];
                pick_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                pick_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ARB: begin
                if (found) begin
                    win_d   = pick;
                    we_d    = pick_we;
                    addr_d  = pick_addr;
                    wdata_d = pick_wdata;
                    if (upd_last) last_d = pick;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = ARB;
                end else begin
                    rdata_d = data_from_mem_i;
                    state_d = RESP;
                end
            end
            RESP:    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ARB;
            last_q  <= IDX_W'(NUM_REQ - 1);
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from state so reset removes them without waiting for a clock.
    always_comb begin
        gnt_w    = '0;
        rvalid_w = '0;
        if (state_q == ACCESS) gnt_w[win_q]    = 1'b1;
        if (state_q == RESP)   rvalid_w[win_q] = 1'b1;
    end

    assign bus.gnt       = gnt_w;
    assign bus.rvalid    = rvalid_w;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state_q != ARB);
    assign addr_mem_o    = addr_q;
    assign data_to_mem_o = wdata_q;
    assign wren_o        = (state_q == ACCESS) && we_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a negedge memory model.
// Rev 1.0 - initial release.
`default_nettype none

module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        logic [N-1:0]  m;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          cd;
    } gexp_t;

    typedef struct {
        logic [N-1:0]  m;
        logic [DW-1:0] d;
    } rexp_t;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] addr_mem;
    logic [DW-1:0] data_to_mem;
    logic          wren;
    logic [DW-1:0] data_from_mem;
    logic [DW-1:0] mem [0:65535];

    gexp_t gq[$];
    rexp_t rq[$];
    int    total = 0;
    int    bad   = 0;

    mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .bus            (bus),
        .addr_mem_o     (addr_mem),
        .data_to_mem_o  (data_to_mem),
        .wren_o         (wren),
        .data_from_mem_i(data_from_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'hC000 + 16'(i % 4096);
    end

    always @(negedge clk) begin
        if (wren) mem[addr_mem] <= data_to_mem;
        data_from_mem <= mem[addr_mem];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_g(input logic [N-1:0] m, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic cd);
        gexp_t e;
        e.m = m; e.wr = wr; e.a = a; e.d = d; e.cd = cd;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic [N-1:0] m, input logic [DW-1:0] d);
        rexp_t e;
        e.m = m; e.d = d;
        rq.push_back(e);
    endtask

    task automatic set_lane(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.we[i]           = w;
        bus.addr[i*AW +: AW] = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    // Counts grants on falling edges; req is dropped in the cycle of the n-th grant.
    task automatic wait_gnts(input int n);
        int cnt = 0;
        for (int k = 0; k < 200 && cnt < n; k++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                cnt++;
                if (cnt == n) bus.req = '0;
            end
        end
        chk("gnt_timeout", cnt, n);
    endtask

    task automatic hold(input logic [N-1:0] mask, input int n);
        @(negedge clk);
        bus.req = mask;
        wait_gnts(n);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!bus.busy && gq.size() == 0 && rq.size() == 0) break;
        end
        chk("idle_timeout", (k < 50), 1);
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every strobe and checks strobe invariants.
    initial begin
        gexp_t        ge;
        rexp_t        re;
        logic [N-1:0] prev_gnt = '0;
        logic         prev_wr  = 1'b0;
        logic [N-1:0] prev_rv  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                prev_gnt = '0; prev_wr = 1'b0; prev_rv = '0;
                continue;
            end
            chk("gnt_onehot", $onehot0(bus.gnt), 1);
            chk("rv_onehot", $onehot0(bus.rvalid), 1);
            chk("gnt_rv_excl", (|bus.gnt) && (|bus.rvalid), 0);
            if (prev_gnt != '0 && !prev_wr) chk("rv_after_gnt", bus.rvalid, prev_gnt);
            if ((prev_gnt != '0 && prev_wr) || prev_rv != '0) chk("busy_in_arb", bus.busy, 0);
            if (bus.gnt != '0) begin
                chk("busy_in_access", bus.busy, 1);
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", bus.gnt, 0);
                end else begin
                    ge = gq.pop_front();
                    chk("gnt", bus.gnt, ge.m);
                    chk("wren", wren, ge.wr);
                    chk("addr_mem", addr_mem, ge.a);
                    if (ge.cd) chk("data_to_mem", data_to_mem, ge.d);
                end
            end else begin
                chk("wren_idle", wren, 0);
            end
            if (bus.rvalid != '0) begin
                chk("busy_in_resp", bus.busy, 1);
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", bus.rvalid, 0);
                end else begin
                    re = rq.pop_front();
                    chk("rvalid", bus.rvalid, re.m);
                    chk("rdata", bus.rdata, re.d);
                end
            end
            prev_gnt = bus.gnt;
            prev_wr  = wren;
            prev_rv  = bus.rvalid;
        end
    end

    initial begin
        int k;
        reset_n   = 1'b0;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gnt", bus.gnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset hits while requester 0's read is in ACCESS; it must vanish.
        for (int i = 0; i < N; i++) set_lane(i, 1'b0, 16'h0030 + 16'(i), 16'h0000);
        push_g(4'b0001, 1'b0, 16'h0030, 16'h0000, 1'b0);
        bus.req = 4'b1111;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_gnt", bus.gnt, 0);
        chk("rst_mid_rvalid", bus.rvalid, 0);
        chk("rst_mid_rdata", bus.rdata, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_wren", wren, 0);
        chk("rst_mid_addr", addr_mem, 0);
        chk("rst_mid_wdata", data_to_mem, 0);
        repeat (2) @(negedge clk);
        push_g(4'b0001, 1'b0, 16'h0030, 16'h0000, 1'b0);
        push_r(4'b0001, 16'hC030);
        reset_n = 1'b1;
        wait_gnts(1);
        wait_idle();

        // Write by requester 2, then read it back through requester 1.
        set_lane(2, 1'b1, 16'h0015, 16'h00AB);
        push_g(4'b0100, 1'b1, 16'h0015, 16'h00AB, 1'b1);
        hold(4'b0100, 1);
        wait_idle();
        set_lane(1, 1'b0, 16'h0015, 16'h0000);
        push_g(4'b0010, 1'b0, 16'h0015, 16'h0000, 1'b0);
        push_r(4'b0010, 16'h00AB);
        @(negedge clk);
        bus.req = 4'b0010;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            k++;
            if (bus.gnt[1]) bus.req[1] = 1'b0;
            if (bus.rvalid[1]) break;
        end
        chk("rd_latency", k + 1, 3);
        wait_idle();

        // Requester 3 withdraws and changes address after issue; access is unaffected.
        set_lane(3, 1'b0, 16'h0020, 16'h0000);
        push_g(4'b1000, 1'b0, 16'h0020, 16'h0000, 1'b0);
        push_r(4'b1000, 16'hC020);
        hold(4'b1000, 1);
        set_lane(3, 1'b0, 16'h0099, 16'h0000);
        @(negedge clk);
        chk("late_chg_addr", addr_mem, 16'h0020);
        chk("late_chg_rv", bus.rvalid, 4'b1000);
        wait_idle();

`ifndef MEMARB_FIXED_PRIO_EN
        // All four read continuously: strict rotation.
        for (int i = 0; i < N; i++) set_lane(i, 1'b0, 16'h0030 + 16'(i), 16'h0000);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                push_g(4'(1 << i), 1'b0, 16'h0030 + 16'(i), 16'h0000, 1'b0);
                push_r(4'(1 << i), 16'hC030 + 16'(i));
            end
        end
        hold(4'b1111, 8);
        wait_idle();
`endif

        // Requesters 1 and 3 write back to back, then requester 0 reads one back.
        set_lane(1, 1'b1, 16'h0040, 16'h1111);
        set_lane(3, 1'b1, 16'h0041, 16'h3333);
        for (int r = 0; r < 2; r++) begin
            push_g(4'b0010, 1'b1, 16'h0040, 16'h1111, 1'b1);
            push_g(4'b1000, 1'b1, 16'h0041, 16'h3333, 1'b1);
        end
        hold(4'b1010, 4);
        wait_idle();
        set_lane(0, 1'b0, 16'h0041, 16'h0000);
        push_g(4'b0001, 1'b0, 16'h0041, 16'h0000, 1'b0);
        push_r(4'b0001, 16'h3333);
        hold(4'b0001, 1);
        wait_idle();

`ifdef MEMARB_FIXED_PRIO_EN
        // Requester 0 dominates while asserted; the rest rotate once it lets go.
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 16'h0050 + 16'(i), 16'hD000 + 16'(i));
        for (int r = 0; r < 3; r++) push_g(4'b0001, 1'b1, 16'h0050, 16'hD000, 1'b1);
        hold(4'b1111, 3);
        for (int i = 1; i < N; i++) push_g(4'(1 << i), 1'b1, 16'h0050 + 16'(i), 16'hD000 + 16'(i), 1'b1);
        hold(4'b1110, 3);
        wait_idle();
`endif

        chk("gq_drained", gq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
